stable_window_checker: RTL and testbench

//  Synthesizable on-chip monitor for the rule "a |-> ##DELAY $stable(b)".
//  It consumes the a/b signal pair that the simulation assertion checks.

---
 rtl/stable_window_checker.sv | 123 ++++++++++++
 tb/tb_stable_window_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stable_window_checker.sv
`default_nettype none
// ============================================================================
// Module   : stable_window_checker
// Function : On-chip monitor for "a |-> ##DELAY $stable(b)" with pass/fail
//            pulses, saturating counters, sticky error and first-fail stamp.
// Revision : 1.0  initial release
// ============================================================================
module stable_window_checker #(
    parameter int WIDTH = 1,
    parameter int DELAY = 2,
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic             first_fail_vld,
    output logic [TS_W-1:0]  first_fail_ts,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [TS_W-1:0]  c_TS_ONE  = TS_W'(1);

    logic [DELAY-1:0] r_pend;
    logic [WIDTH-1:0] r_b_q;
    logic [TS_W-1:0]  r_cyc;
    logic             r_pass;
    logic             r_fail;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_err;
    logic             r_ffv;
    logic [TS_W-1:0]  r_ff_ts;

    logic             w_trig;
    logic             w_eval;
    logic             w_same;
    logic             w_pass;
    logic             w_fail;
    logic [DELAY-1:0] w_pend_nxt;

    assign w_trig = a_in & en;
    assign w_eval = r_pend[DELAY-1];
    assign w_same = (b_in == r_b_q);
    assign w_pass = w_eval & w_same;
    assign w_fail = w_eval & ~w_same;

    // One slot per edge of latency; the oldest slot marks an attempt due now.
    generate
        if (DELAY == 1) begin : g_pend_single
            assign w_pend_nxt = w_trig;
        end else begin : g_pend_shift
            assign w_pend_nxt = {r_pend[DELAY-2:0], w_trig};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_b_q      <= '0;
            r_cyc      <= '0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_err      <= 1'b0;
            r_ffv      <= 1'b0;
            r_ff_ts    <= '0;
        end else begin
            r_cyc <= r_cyc + c_TS_ONE;
            r_b_q <= b_in;
            // clr discards the evaluation and the trigger of this same edge.
            if (clr) begin
                r_pend     <= '0;
                r_pass     <= 1'b0;
                r_fail     <= 1'b0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_err      <= 1'b0;
                r_ffv      <= 1'b0;
                r_ff_ts    <= '0;
            end else begin
                r_pend <= w_pend_nxt;
                r_pass <= w_pass;
                r_fail <= w_fail;
                if (w_pass && (r_pass_cnt != c_CNT_MAX)) begin
                    r_pass_cnt <= r_pass_cnt + c_CNT_ONE;
                end
                if (w_fail) begin
                    r_err <= 1'b1;
                    if (r_fail_cnt != c_CNT_MAX) begin
                        r_fail_cnt <= r_fail_cnt + c_CNT_ONE;
                    end
                    if (!r_ffv) begin
                        r_ffv   <= 1'b1;
                        r_ff_ts <= r_cyc;
                    end
                end
            end
        end
    end

    assign pass_o         = r_pass;
    assign fail_o         = r_fail;
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign err_sticky     = r_err;
    assign first_fail_vld = r_ffv;
    assign first_fail_ts  = r_ff_ts;
    assign busy           = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_stable_window_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_stable_window_checker
// Function : Directed and randomized checks of two checker instances against
//            a trigger-time reference model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stable_window_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        clr = 1'b0;
    logic        a   = 1'b0;
    logic [3:0]  b   = 4'h0;

    logic        p0, f0, err0, ffv0, busy0;
    logic [2:0]  pc0, fc0;
    logic [31:0] ts0;
    logic        p1, f1, err1, ffv1, busy1;
    logic [15:0] pc1, fc1;
    logic [7:0]  ts1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stable_window_checker #(.WIDTH(1), .DELAY(2), .CNT_W(3), .TS_W(32)) dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a_in(a), .b_in(b[0]),
        .pass_o(p0), .fail_o(f0), .pass_cnt(pc0), .fail_cnt(fc0),
        .err_sticky(err0), .first_fail_vld(ffv0), .first_fail_ts(ts0), .busy(busy0)
    );

    stable_window_checker #(.WIDTH(4), .DELAY(3), .CNT_W(16), .TS_W(8)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a_in(a), .b_in(b),
        .pass_o(p1), .fail_o(f1), .pass_cnt(pc1), .fail_cnt(fc1),
        .err_sticky(err1), .first_fail_vld(ffv1), .first_fail_ts(ts1), .busy(busy1)
    );

    // Reference model: remembers the edge number of each accepted trigger and
    // judges an attempt when the current edge is exactly DELAY edges later.
    int       D[2]    = '{2, 3};
    int       CMAX[2] = '{7, 65535};
    int       mpc[2], mfc[2], mts[2];
    bit       mpo[2], mfo[2], merr[2], mffv[2], mbusy[2];
    bit       trig[int];
    int       last_clr = -1;
    int       mcyc = 0;
    logic [3:0] bprev = 4'h0;

    task automatic model_step();
        int t;
        bit same;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mpc[i] = 0; mfc[i] = 0; mts[i] = 0;
                mpo[i] = 0; mfo[i] = 0; merr[i] = 0; mffv[i] = 0; mbusy[i] = 0;
            end
            trig.delete();
            last_clr = -1;
            mcyc = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                t    = mcyc - D[i];
                same = (i == 0) ? (b[0] == bprev[0]) : (b == bprev);
                mpo[i] = 0;
                mfo[i] = 0;
                if (clr) begin
                    mpc[i] = 0; mfc[i] = 0; mts[i] = 0; merr[i] = 0; mffv[i] = 0;
                end else if (t > last_clr && trig.exists(t)) begin
                    if (same) begin
                        mpo[i] = 1;
                        if (mpc[i] < CMAX[i]) mpc[i]++;
                    end else begin
                        mfo[i]  = 1;
                        merr[i] = 1;
                        if (mfc[i] < CMAX[i]) mfc[i]++;
                        if (!mffv[i]) begin
                            mffv[i] = 1;
                            mts[i]  = (i == 0) ? mcyc : (mcyc % 256);
                        end
                    end
                end
            end
            if (clr) last_clr = mcyc;
            else if (a && en) trig[mcyc] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                mbusy[i] = 0;
                for (int k = 0; k < D[i]; k++) begin
                    if (trig.exists(mcyc - k) && (mcyc - k) > last_clr) mbusy[i] = 1;
                end
            end
            if (trig.exists(mcyc - 8)) trig.delete(mcyc - 8);
            mcyc++;
        end
        bprev = b;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit aa, input logic [3:0] bb);
        rst = r; en = e; clr = c; a = aa; b = bb;
        model_step();
        @(negedge clk);
        #1;
    endtask

    // Every-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        chk("m_pass_o0", p0, mpo[0]);
        chk("m_fail_o0", f0, mfo[0]);
        chk("m_pass_cnt0", pc0, mpc[0]);
        chk("m_fail_cnt0", fc0, mfc[0]);
        chk("m_err0", err0, merr[0]);
        chk("m_ffv0", ffv0, mffv[0]);
        chk("m_ffts0", ts0, mts[0]);
        chk("m_busy0", busy0, mbusy[0]);
        chk("m_pass_o1", p1, mpo[1]);
        chk("m_fail_o1", f1, mfo[1]);
        chk("m_pass_cnt1", pc1, mpc[1]);
        chk("m_fail_cnt1", fc1, mfc[1]);
        chk("m_err1", err1, merr[1]);
        chk("m_ffv1", ffv1, mffv[1]);
        chk("m_ffts1", ts1, mts[1]);
        chk("m_busy1", busy1, mbusy[1]);
    end

    initial begin
        logic [3:0] nb;
        bit r, c;
        step(1, 0, 0, 0, 4'h0);
        step(1, 0, 0, 0, 4'h0);
        chk("rst_pass_cnt", pc0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_ffv", ffv0, 0);

        // basic pass: edges 0..9
        for (int cy = 0; cy < 10; cy++) begin
            step(0, 1, 0, (cy == 2 || cy == 3), (cy >= 2) ? 4'hF : 4'h0);
            if (cy == 4) chk("pass_e4", p0, 1);
            if (cy == 5) begin
                chk("pass_e5", p0, 1);
                chk("pass_cnt2", pc0, 2);
                chk("pass_nofail", fc0, 0);
            end
        end
        // basic fail: edges 10..19
        for (int cy = 10; cy < 20; cy++) begin
            step(0, 1, 0, (cy == 10), (cy >= 12) ? 4'hF : 4'h0);
            if (cy == 12) begin
                chk("fail_e12", f0, 1);
                chk("fail_cnt1", fc0, 1);
                chk("fail_err", err0, 1);
                chk("fail_ts12", ts0, 12);
            end
        end
        // overlap + late change: edges 20..29
        for (int cy = 20; cy < 30; cy++) begin
            step(0, 1, 0, (cy >= 20 && cy <= 23),
                 (cy >= 26) ? ((cy % 2 == 0) ? 4'h0 : 4'hF) : 4'hF);
            if (cy >= 22 && cy <= 25) begin
                chk("ovl_pass", p0, 1);
                chk("ovl_nofail", f0, 0);
            end
            if (cy == 25) begin
                chk("ovl_busy0", busy0, 0);
                chk("ovl_cnt6", pc0, 6);
            end
        end
        // trigger at 30, reset at 31
        step(0, 1, 0, 1, 4'h0);
        step(1, 1, 0, 0, 4'h0);
        chk("rst_mid_pc", pc0, 0);
        chk("rst_mid_fc", fc0, 0);
        chk("rst_mid_err", err0, 0);
        chk("rst_mid_ts", ts0, 0);
        chk("rst_mid_busy", busy0, 0);
        step(0, 1, 0, 0, 4'h0);
        chk("rst_mid_nopass", p0, 0);
        chk("rst_mid_nofail", f0, 0);
        // clr collision: edges 1..6
        step(0, 1, 0, 1, 4'h0);
        step(0, 1, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'hF);
        chk("pre_clr_fail", f0, 1);
        chk("pre_clr_fc", fc0, 1);
        step(0, 1, 0, 1, 4'hF);
        step(0, 1, 0, 0, 4'hF);
        step(0, 1, 1, 0, 4'h0);
        chk("clr_nofail", f0, 0);
        chk("clr_fc", fc0, 0);
        chk("clr_pc", pc0, 0);
        chk("clr_err", err0, 0);
        chk("clr_ffv", ffv0, 0);
        // saturation: triggers 7..15, b toggles every edge, fails at 9..17
        for (int cy = 7; cy < 18; cy++) begin
            step(0, 1, 0, (cy <= 15), (cy % 2 == 1) ? 4'hF : 4'h0);
            if (cy == 9) chk("sat_first_fail", f0, 1);
        end
        chk("sat_fc7", fc0, 7);
        chk("sat_ts9", ts0, 9);
        // en gating: edges 18..24, en=0 with a=1 for 18..22
        for (int cy = 18; cy < 25; cy++) begin
            step(0, (cy >= 23), 0, (cy <= 22), (cy % 2 == 1) ? 4'hF : 4'h0);
            chk("en0_nopass", p0, 0);
            chk("en0_nofail", f0, 0);
        end
        // trigger at 25 with en=1, en=0 afterwards
        step(0, 1, 0, 1, 4'hF);
        step(0, 0, 0, 1, 4'h0);
        step(0, 0, 0, 1, 4'hF);
        chk("en_inflight_fail", f0, 1);
        step(0, 0, 0, 1, 4'h0);
        chk("en_blocked", f0, 0);

        // randomized phase
        nb = b;
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 999) == 0);
            c = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 99) < 35) nb = nb ^ 4'($urandom_range(1, 15));
            step(r, ($urandom_range(0, 9) != 0), c, 1'($urandom_range(0, 1)), nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
